// File: rtl/divisor_ruta_datos.sv
// Datapath of the restoring divider. Driven by the divider control FSM through a
// one-hot state vector; returns the two status flags the FSM branches on and
// presents the quotient/remainder with a ready flag.
module divisor_ruta_datos #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [7:0]       est,
  input  logic [WIDTH-1:0] dividendo_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             divisor_no_cero,
  output logic             cont16_no_cero,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             listo,
  output logic             div_cero,
  output logic             est_invalido
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned DW = WIDTH + 2;

  logic [WIDTH-1:0] d_reg, d_nxt;
  logic [WIDTH-1:0] b_reg, b_nxt;
  logic [RW-1:0]    r_reg, r_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [CW-1:0]    cnt,   cnt_nxt;
  logic [WIDTH-1:0] cociente_nxt;
  logic [WIDTH-1:0] residuo_nxt;
  logic             listo_nxt;
  logic             div_cero_nxt;
  logic [DW-1:0]    dif;

  // State vector must have exactly one bit set
  assign est_invalido    = (est == 8'd0) || ((est & (est - 8'd1)) != 8'd0);

  // Status flags straight from the registers
  assign divisor_no_cero = |b_reg;
  assign cont16_no_cero  = (cnt != CW'(0));

  // Next-value selection for the active FSM state
  always_comb begin
    d_nxt        = d_reg;
    b_nxt        = b_reg;
    r_nxt        = r_reg;
    q_nxt        = q_reg;
    cnt_nxt      = cnt;
    cociente_nxt = cociente;
    residuo_nxt  = residuo;
    listo_nxt    = listo;
    div_cero_nxt = div_cero;
    // Extra top bit of the difference is the borrow
    dif          = {1'b0, r_reg} - {2'b00, b_reg};

    if (!est_invalido) begin
      if (est[0]) begin
        d_nxt = dividendo_in;
        b_nxt = divisor_in;
      end else if (est[1]) begin
        if (b_reg == '0) begin
          div_cero_nxt = 1'b1;
          cociente_nxt = {WIDTH{1'b1}};
          residuo_nxt  = d_reg;
          listo_nxt    = 1'b1;
        end else begin
          div_cero_nxt = 1'b0;
        end
      end else if (est[2]) begin
        r_nxt     = '0;
        q_nxt     = d_reg;
        cnt_nxt   = CW'(WIDTH);
        listo_nxt = 1'b0;
      end else if (est[3]) begin
        r_nxt = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        q_nxt = {q_reg[WIDTH-2:0], 1'b0};
      end else if (est[4]) begin
        if (!dif[DW-1]) begin
          r_nxt    = dif[RW-1:0];
          q_nxt[0] = 1'b1;
        end else begin
          q_nxt[0] = 1'b0;
        end
        cnt_nxt = cnt - CW'(1);
      end else if (est[6]) begin
        cociente_nxt = q_reg;
        residuo_nxt  = r_reg[WIDTH-1:0];
        listo_nxt    = 1'b1;
      end
    end
  end

  // All registers update on the falling edge, in step with the FSM
  always_ff @(negedge reloj or negedge reset) begin
    if (!reset) begin
      d_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      cnt      <= '0;
      cociente <= '0;
      residuo  <= '0;
      listo    <= 1'b0;
      div_cero <= 1'b0;
    end else begin
      d_reg    <= d_nxt;
      b_reg    <= b_nxt;
      r_reg    <= r_nxt;
      q_reg    <= q_nxt;
      cnt      <= cnt_nxt;
      cociente <= cociente_nxt;
      residuo  <= residuo_nxt;
      listo    <= listo_nxt;
      div_cero <= div_cero_nxt;
    end
  end

endmodule

// File: tb/tb_divisor_ruta_datos.sv
// Bench for divisor_ruta_datos: plays the control FSM, pushes expected results
// into a queue and lets a monitor compare them whenever listo rises.
module tb_divisor_ruta_datos;

  localparam logic [7:0] E0 = 8'h01, E1 = 8'h02, E2 = 8'h04, E3 = 8'h08;
  localparam logic [7:0] E4 = 8'h10, E5 = 8'h20, E6 = 8'h40, E7 = 8'h80;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } res_t;

  logic        reloj;
  logic        reset;
  logic [7:0]  est;
  logic [15:0] dividendo_in;
  logic [15:0] divisor_in;
  logic        divisor_no_cero;
  logic        cont16_no_cero;
  logic [15:0] cociente;
  logic [15:0] residuo;
  logic        listo;
  logic        div_cero;
  logic        est_invalido;

  int   n_tests;
  int   n_fail;
  int   n_seen;
  bit   scramble;
  logic listo_prev;
  res_t exp_q[$];

  divisor_ruta_datos #(.WIDTH(16)) dut (
    .reloj           (reloj),
    .reset           (reset),
    .est             (est),
    .dividendo_in    (dividendo_in),
    .divisor_in      (divisor_in),
    .divisor_no_cero (divisor_no_cero),
    .cont16_no_cero  (cont16_no_cero),
    .cociente        (cociente),
    .residuo         (residuo),
    .listo           (listo),
    .div_cero        (div_cero),
    .est_invalido    (est_invalido)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  // One FSM step: state driven after the rising edge, applied on the falling edge
  task automatic apply(input logic [7:0] e);
    @(posedge reloj);
    est = e;
    if (scramble) begin
      dividendo_in = 16'($urandom);
      divisor_in   = 16'($urandom);
    end
    @(negedge reloj);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cociente"}, 32'(cociente), 32'd0);
    chk({tag, "_residuo"},  32'(residuo),  32'd0);
    chk({tag, "_listo"},    32'(listo),    32'd0);
    chk({tag, "_div_cero"}, 32'(div_cero), 32'd0);
    chk({tag, "_divnz"},    32'(divisor_no_cero), 32'd0);
    chk({tag, "_cntnz"},    32'(cont16_no_cero),  32'd0);
  endtask

  // Full division as the FSM sequences it; optional invalid-state burst or reset abort
  task automatic run_div(input logic [15:0] dd, input logic [15:0] dv,
                         input logic [15:0] eq, input logic [15:0] er,
                         input bit scr, input int inv_at, input int abort_at);
    res_t e;
    if (abort_at == 0) begin
      e.q  = eq;
      e.r  = er;
      e.dz = (dv == 16'd0);
      exp_q.push_back(e);
    end
    scramble     = 1'b0;
    dividendo_in = dd;
    divisor_in   = dv;
    apply(E0);
    chk("divisor_no_cero", 32'(divisor_no_cero), 32'(dv != 16'd0));
    scramble = scr;
    apply(E1);
    if (dv == 16'd0) begin
      apply(E7);
      apply(E7);
      scramble = 1'b0;
      return;
    end
    apply(E2);
    chk("cnt_init_nz", 32'(cont16_no_cero), 32'd1);
    chk("listo_cleared", 32'(listo), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      apply(E3);
      if (k == abort_at) begin
        @(posedge reloj);
        est = E4;
        #2 reset = 1'b0;
        #1 chk_all_zero("abort");
        @(posedge reloj);
        reset    = 1'b1;
        scramble = 1'b0;
        return;
      end
      apply(E4);
      chk("cont16_no_cero", 32'(cont16_no_cero), 32'(k != 16));
      if (k == inv_at) begin
        apply(8'h00);
        chk("inv_zero_flag", 32'(est_invalido), 32'd1);
        chk("inv_zero_cnt",  32'(cont16_no_cero), 32'd1);
        apply(8'h03);
        chk("inv_multi_flag", 32'(est_invalido), 32'd1);
        apply(8'h03);
        chk("inv_multi_cnt", 32'(cont16_no_cero), 32'd1);
        chk("inv_listo",     32'(listo), 32'd0);
      end
      apply(E5);
      if (k == inv_at) chk("valid_flag", 32'(est_invalido), 32'd0);
    end
    apply(E6);
    apply(E7);
    apply(E7);
    scramble = 1'b0;
  endtask

  // Monitor: compare against the scoreboard each time listo rises
  initial begin
    res_t e;
    listo_prev = 1'b0;
    forever begin
      @(posedge reloj);
      if (listo && !listo_prev) begin
        n_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cociente", 32'(cociente), 32'(e.q));
          chk("residuo",  32'(residuo),  32'(e.r));
          chk("div_cero", 32'(div_cero), 32'(e.dz));
        end
      end
      listo_prev = listo;
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    n_seen       = 0;
    scramble     = 1'b0;
    reset        = 1'b0;
    est          = E0;
    dividendo_in = 16'd0;
    divisor_in   = 16'd0;
    #12;
    chk_all_zero("reset");
    chk("reset_est_invalido", 32'(est_invalido), 32'd0);
    @(posedge reloj);
    reset = 1'b1;

    // Divide by zero first so listo rises from its reset value
    run_div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b0, 0, 0);
    run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0, 0);
    run_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0, 0);
    run_div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 0, 0);
    run_div(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 0, 0);
    run_div(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 0, 0);
    // Reset during the 5th trial subtract, then a clean run
    run_div(16'd1234, 16'd5, 16'd0, 16'd0, 1'b0, 0, 5);
    run_div(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 0, 0);
    // Invalid state vectors mid-iteration
    run_div(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 7, 0);
    // Operand inputs scrambled outside E0
    run_div(16'd65000, 16'd250, 16'd260, 16'd0, 1'b1, 0, 0);
    run_div(16'd12345, 16'd100, 16'd123, 16'd45, 1'b1, 0, 0);

    repeat (4) @(posedge reloj);
    #1;
    chk("results_seen", 32'(n_seen), 32'd10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
